// File: rtl/opc6_bus_responder_pkg.sv
// Shared constants for the OPC6 bus responder: IO register map, CTRL/STATUS bit
// positions, int_b bit positions and the CPU interrupt vectors.
package opc6_bus_pkg;

  // IO register offsets, selected by address[2:0]
  localparam logic [2:0] IoCtrl   = 3'd0;
  localparam logic [2:0] IoReload = 3'd1;
  localparam logic [2:0] IoCount  = 3'd2;
  localparam logic [2:0] IoStatus = 3'd3;

  // CTRL bits
  localparam int unsigned CtrlEn   = 0;
  localparam int unsigned CtrlIe   = 1;
  localparam int unsigned CtrlAuto = 2;

  // STATUS bits
  localparam int unsigned StatTpend = 0;
  localparam int unsigned StatXpend = 1;

  // int_b bits
  localparam int unsigned IntExt   = 0;
  localparam int unsigned IntTimer = 1;

  // Interrupt vectors taken by the CPU for each int_b line
  localparam logic [15:0] VecExt   = 16'h0002;
  localparam logic [15:0] VecTimer = 16'h0004;

  typedef struct packed {
    logic auto_reload;
    logic ie;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/opc6_bus_responder_if.sv
// OPC6 CPU bus. The CPU side uses the master modport, the responder the slave.
//  address/cpu_dout/rnw/vpa/vda/vio : CPU -> responder
//  cpu_din/clken/int_b              : responder -> CPU
interface opc6_bus_if;
  logic [15:0] address;
  logic [15:0] cpu_dout;
  logic        rnw;
  logic        vpa;
  logic        vda;
  logic        vio;
  logic [15:0] cpu_din;
  logic        clken;
  logic [1:0]  int_b;

  modport master (
    output address, cpu_dout, rnw, vpa, vda, vio,
    input  cpu_din, clken, int_b
  );

  modport slave (
    input  address, cpu_dout, rnw, vpa, vda, vio,
    output cpu_din, clken, int_b
  );
endinterface

// File: rtl/opc6_bus_responder_io_timer.sv
// Interval timer for the OPC6 IO register file: prescaler, down counter, CTRL and
// RELOAD registers. Emits a one-cycle tpend_set_o on each expiry; the parent owns STATUS.
//  clk, reset_b     : clock, synchronous active-low reset
//  io_we_i          : IO write strobe (commits on this posedge)
//  io_sel_i         : register select
//  io_wdata_i       : write data
//  ctrl_o, reload_o, count_o : register contents for IO reads
//  tpend_set_o      : expiry pulse
module opc6_io_timer
  import opc6_bus_pkg::*;
#(
  parameter logic [15:0] PRESCALE = 16'd0
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        io_we_i,
  input  logic [2:0]  io_sel_i,
  input  logic [15:0] io_wdata_i,
  output ctrl_t       ctrl_o,
  output logic [15:0] reload_o,
  output logic [15:0] count_o,
  output logic        tpend_set_o
);

  ctrl_t       ctrl_q, ctrl_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic [15:0] pre_q, pre_d;
  logic        tick;

  always_comb begin
    ctrl_d      = ctrl_q;
    reload_d    = reload_q;
    count_d     = count_q;
    pre_d       = '0;
    tpend_set_o = 1'b0;
    tick        = ctrl_q.en && (pre_q == PRESCALE);

    if (ctrl_q.en) begin
      pre_d = tick ? 16'd0 : pre_q + 16'd1;
    end

    if (tick) begin
      if (count_q == 16'd0) begin
        tpend_set_o = 1'b1;
        if (ctrl_q.auto_reload) begin
          count_d = reload_q;
        end else begin
          ctrl_d.en = 1'b0;
        end
      end else begin
        count_d = count_q - 16'd1;
      end
    end

    // A register write overrides the timer's own CTRL update in the same cycle
    if (io_we_i) begin
      unique case (io_sel_i)
        IoCtrl: begin
          ctrl_d = ctrl_t'(io_wdata_i[2:0]);
          if (!ctrl_q.en && io_wdata_i[CtrlEn]) begin
            count_d = reload_q;
            pre_d   = '0;
          end
        end
        IoReload: reload_d = io_wdata_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      ctrl_q   <= '0;
      reload_q <= '0;
      count_q  <= '0;
      pre_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      pre_q    <= pre_d;
    end
  end

  assign ctrl_o   = ctrl_q;
  assign reload_o = reload_q;
  assign count_o  = count_q;

endmodule

// File: rtl/opc6_bus_responder.sv
// OPC6 bus target: wait-stated block RAM, IO register file (timer + interrupt status)
// and the CPU's active-low interrupt lines.
//  clk, reset_b : clock shared with the CPU, synchronous active-low reset
//  ext_irq_b    : external interrupt request, active-low level
//  bus          : OPC6 bus, slave side (address/data/strobes in, cpu_din/clken/int_b out)
// Build option: define OPC6_IO_TIMER_EN to include the interval timer; without it
// CTRL/RELOAD/COUNT and TPEND read 0 and int_b[1] is held high.
module opc6_bus_responder
  import opc6_bus_pkg::*;
#(
  parameter int unsigned MEM_AW      = 12,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [15:0] PRESCALE    = 16'd0
) (
  input  logic      clk,
  input  logic      reset_b,
  input  logic      ext_irq_b,
  opc6_bus_if.slave bus
);

  localparam int unsigned        WcntW   = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [WcntW-1:0]   WaitMax = WcntW'(WAIT_STATES);

  logic [15:0]       mem_q [(1 << MEM_AW)];
  logic [15:0]       rdata_q;
  logic [WcntW-1:0]  wcnt_q, wcnt_d;
  logic              tpend_q, tpend_d;
  logic              xpend_q, xpend_d;
  logic [1:0]        int_b_q, int_b_d;

  logic              mem_cyc, mem_done, mem_we, io_we, clken;
  logic [MEM_AW-1:0] mem_addr;
  logic [15:0]       io_rdata;

  ctrl_t             ctrl;
  logic [15:0]       reload, count;
  logic              tpend_set;

  logic              unused_addr;
  assign unused_addr = ^bus.address[15:MEM_AW];

  assign mem_cyc  = (bus.vpa || bus.vda) && !bus.vio;
  assign mem_done = mem_cyc && (wcnt_q == WaitMax);
  assign mem_addr = bus.address[MEM_AW-1:0];
  // Held high in reset so the CPU reset synchroniser keeps advancing
  assign clken    = !reset_b || !mem_cyc || mem_done;
  // Gated by reset_b so an access cut short by reset never writes RAM
  assign mem_we   = reset_b && mem_done && !bus.rnw;
  assign io_we    = reset_b && bus.vio && !bus.rnw;

`ifdef OPC6_IO_TIMER_EN
  opc6_io_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk         (clk),
    .reset_b     (reset_b),
    .io_we_i     (io_we),
    .io_sel_i    (bus.address[2:0]),
    .io_wdata_i  (bus.cpu_dout),
    .ctrl_o      (ctrl),
    .reload_o    (reload),
    .count_o     (count),
    .tpend_set_o (tpend_set)
  );
`else
  logic [15:0] unused_prescale;
  assign unused_prescale = PRESCALE;
  assign ctrl      = '0;
  assign reload    = '0;
  assign count     = '0;
  assign tpend_set = 1'b0;
`endif

  always_comb begin
    io_rdata = '0;
    case (bus.address[2:0])
      IoCtrl:   io_rdata = {13'd0, ctrl};
      IoReload: io_rdata = reload;
      IoCount:  io_rdata = count;
      IoStatus: io_rdata = {14'd0, xpend_q, tpend_q};
      default:  io_rdata = '0;
    endcase
  end

  always_comb begin
    wcnt_d = '0;
    if (mem_cyc && !mem_done) begin
      wcnt_d = wcnt_q + 1'b1;
    end

    // Set wins over write-one-to-clear
    tpend_d = tpend_q;
    xpend_d = xpend_q;
    if (io_we && bus.address[2:0] == IoStatus) begin
      if (bus.cpu_dout[StatTpend]) tpend_d = 1'b0;
      if (bus.cpu_dout[StatXpend]) xpend_d = 1'b0;
    end
    if (tpend_set) tpend_d = 1'b1;
    if (!ext_irq_b) xpend_d = 1'b1;

    int_b_d           = 2'b11;
    int_b_d[IntExt]   = !xpend_q;
`ifdef OPC6_IO_TIMER_EN
    int_b_d[IntTimer] = !(tpend_q && ctrl.ie);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      wcnt_q  <= '0;
      tpend_q <= 1'b0;
      xpend_q <= 1'b0;
      int_b_q <= 2'b11;
    end else begin
      wcnt_q  <= wcnt_d;
      tpend_q <= tpend_d;
      xpend_q <= xpend_d;
      int_b_q <= int_b_d;
    end
  end

  // RAM is not reset; the synchronous read port samples the address every cycle
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= bus.cpu_dout;
    end
    rdata_q <= mem_q[mem_addr];
  end

  always_comb begin
    bus.cpu_din = '0;
    if (reset_b) begin
      if (bus.vio) begin
        bus.cpu_din = io_rdata;
      end else if (mem_done) begin
        bus.cpu_din = rdata_q;
      end
    end
  end

  assign bus.clken = clken;
  assign bus.int_b = int_b_q;

endmodule

// File: tb/tb_opc6_bus_responder.sv
module tb_opc6_bus_responder;
  import opc6_bus_pkg::*;

  logic clk = 1'b0;
  logic reset_b;
  logic ext_irq_b;
  int   vectors = 0;
  int   miscompares = 0;

  opc6_bus_if bus_if ();

  opc6_bus_responder #(
    .MEM_AW      (12),
    .WAIT_STATES (1),
    .PRESCALE    (16'd0)
  ) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .ext_irq_b (ext_irq_b),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.vpa = 1'b0;
    bus_if.vda = 1'b0;
    bus_if.vio = 1'b0;
    bus_if.rnw = 1'b1;
    #1;
  endtask

  task automatic io_wr(input logic [2:0] a, input logic [15:0] d);
    bus_if.vio = 1'b1;
    bus_if.rnw = 1'b0;
    bus_if.address = {13'd0, a};
    bus_if.cpu_dout = d;
    #1;
    tick();
    idle();
  endtask

  task automatic io_rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
    bus_if.vio = 1'b1;
    bus_if.rnw = 1'b1;
    bus_if.address = {13'd0, a};
    #1;
    chk(tag, bus_if.cpu_din, exp);
    chk({tag, "_clken"}, {15'd0, bus_if.clken}, 16'd1);
  endtask

  task automatic mem_set(input logic v_pa, input logic rd, input logic [15:0] a,
                         input logic [15:0] d);
    bus_if.vio = 1'b0;
    bus_if.vpa = v_pa;
    bus_if.vda = !v_pa;
    bus_if.rnw = rd;
    bus_if.address = a;
    bus_if.cpu_dout = d;
    #1;
  endtask

  initial begin
    reset_b = 1'b0;
    ext_irq_b = 1'b1;
    bus_if.address = 16'h0000;
    bus_if.cpu_dout = 16'h0000;
    bus_if.rnw = 1'b1;
    bus_if.vpa = 1'b0;
    bus_if.vda = 1'b1;
    bus_if.vio = 1'b0;

    // Reset with a memory strobe active
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_clken", {15'd0, bus_if.clken}, 16'd1);
      chk("rst_int_b", {14'd0, bus_if.int_b}, 16'h0003);
      chk("rst_din", bus_if.cpu_din, 16'h0000);
    end
    reset_b = 1'b1;
    idle();
    chk("idle_clken", {15'd0, bus_if.clken}, 16'd1);
    chk("idle_din", bus_if.cpu_din, 16'h0000);

    // Write 0x0123 <= BEEF: one stall cycle then completion
    mem_set(1'b0, 1'b0, 16'h0123, 16'hBEEF);
    chk("wr_stall", {15'd0, bus_if.clken}, 16'd0);
    tick();
    chk("wr_done", {15'd0, bus_if.clken}, 16'd1);
    tick();
    // Read back
    mem_set(1'b0, 1'b1, 16'h0123, 16'h0000);
    chk("rd_stall", {15'd0, bus_if.clken}, 16'd0);
    tick();
    chk("rd_done", {15'd0, bus_if.clken}, 16'd1);
    chk("rd_data", bus_if.cpu_din, 16'hBEEF);
    tick();
    // Back-to-back alias read restarts the wait counter
    mem_set(1'b0, 1'b1, 16'h1123, 16'h0000);
    chk("alias_stall", {15'd0, bus_if.clken}, 16'd0);
    tick();
    chk("alias_data", bus_if.cpu_din, 16'hBEEF);
    tick();
    // Second location, then program-fetch read of the first
    mem_set(1'b0, 1'b0, 16'h0124, 16'h1234);
    tick();
    tick();
    mem_set(1'b0, 1'b1, 16'h0124, 16'h0000);
    tick();
    chk("rd124", bus_if.cpu_din, 16'h1234);
    tick();
    mem_set(1'b1, 1'b1, 16'h0123, 16'h0000);
    chk("vpa_stall", {15'd0, bus_if.clken}, 16'd0);
    tick();
    chk("vpa_data", bus_if.cpu_din, 16'hBEEF);
    tick();

    // Reset on the completing cycle of a write: RAM must be untouched
    mem_set(1'b0, 1'b0, 16'h0123, 16'hDEAD);
    tick();
    reset_b = 1'b0;
    #1;
    chk("rstw_clken", {15'd0, bus_if.clken}, 16'd1);
    tick();
    reset_b = 1'b1;
    idle();
    tick();
    mem_set(1'b0, 1'b1, 16'h0123, 16'h0000);
    tick();
    chk("rstw_keep", bus_if.cpu_din, 16'hBEEF);
    tick();
    idle();

    // External interrupt: one-cycle pulse latches XPEND
    ext_irq_b = 1'b0;
    #1;
    tick();
    ext_irq_b = 1'b1;
    #1;
    chk("ext_lag", {14'd0, bus_if.int_b}, 16'h0003);
    tick();
    chk("ext_int", {14'd0, bus_if.int_b}, 16'h0002);
    io_rd("st_x", IoStatus, 16'h0002);
    tick();
    idle();
    tick();
    chk("ext_hold", {14'd0, bus_if.int_b}, 16'h0002);
    io_wr(IoStatus, 16'h0002);
    tick();
    chk("ext_clr", {14'd0, bus_if.int_b}, 16'h0003);
    // Set beats clear in the same cycle
    ext_irq_b = 1'b0;
    io_wr(IoStatus, 16'h0002);
    ext_irq_b = 1'b1;
    io_rd("st_setwins", IoStatus, 16'h0002);
    idle();
    io_wr(IoStatus, 16'h0002);
    io_rd("st_clr", IoStatus, 16'h0000);
    idle();
    tick();
    chk("ext_clr2", {14'd0, bus_if.int_b}, 16'h0003);

    // Unused IO slots
    io_wr(3'd5, 16'hFFFF);
    io_rd("io5", 3'd5, 16'h0000);
    io_rd("io7", 3'd7, 16'h0000);
    idle();

`ifdef OPC6_IO_TIMER_EN
    // Autoreload timer, RELOAD=3: COUNT 3,2,1,0,3 with expiries every 4 ticks
    io_wr(IoReload, 16'd3);
    io_rd("reload", IoReload, 16'd3);
    idle();
    io_wr(IoCtrl, 16'h0007);                   // T0
    io_rd("cnt_t0", IoCount, 16'd3);
    tick();                                    // T1
    io_rd("cnt_t1", IoCount, 16'd2);
    tick();                                    // T2
    io_rd("cnt_t2", IoCount, 16'd1);
    tick();                                    // T3
    io_rd("cnt_t3", IoCount, 16'd0);
    chk("int_t3", {14'd0, bus_if.int_b}, 16'h0003);
    tick();                                    // T4 expiry
    io_rd("cnt_t4", IoCount, 16'd3);
    io_rd("st_t4", IoStatus, 16'h0001);
    chk("int_t4", {14'd0, bus_if.int_b}, 16'h0003);
    tick();                                    // T5
    chk("int_t5", {14'd0, bus_if.int_b}, 16'h0001);
    io_wr(IoStatus, 16'h0001);                 // T6 clear
    chk("int_t6", {14'd0, bus_if.int_b}, 16'h0001);
    io_rd("st_t6", IoStatus, 16'h0000);
    tick();                                    // T7
    chk("int_t7", {14'd0, bus_if.int_b}, 16'h0003);
    io_rd("cnt_t7", IoCount, 16'd0);
    tick();                                    // T8 expiry
    io_rd("st_t8", IoStatus, 16'h0001);
    tick();                                    // T9
    chk("int_t9", {14'd0, bus_if.int_b}, 16'h0001);
    tick();                                    // T10
    tick();                                    // T11
    io_rd("cnt_t11", IoCount, 16'd0);
    io_wr(IoStatus, 16'h0001);                 // T12: clear on expiry cycle
    io_rd("st_t12", IoStatus, 16'h0001);
    io_rd("cnt_t12", IoCount, 16'd3);
    tick();                                    // T13
    chk("int_t13", {14'd0, bus_if.int_b}, 16'h0001);
    idle();
    io_wr(IoCtrl, 16'h0000);
    io_wr(IoStatus, 16'h0001);
    tick();
    chk("int_off", {14'd0, bus_if.int_b}, 16'h0003);

    // One-shot: expiry clears EN and COUNT stays at 0
    io_wr(IoReload, 16'd1);
    io_wr(IoCtrl, 16'h0003);
    io_rd("os_c1", IoCount, 16'd1);
    tick();
    io_rd("os_c0", IoCount, 16'd0);
    tick();
    io_rd("os_ctrl", IoCtrl, 16'h0002);
    io_rd("os_st", IoStatus, 16'h0001);
    tick();
    io_rd("os_hold", IoCount, 16'd0);
    chk("os_int", {14'd0, bus_if.int_b}, 16'h0001);
`else
    // Timer absent: registers read 0, int_b[1] never asserts
    io_wr(IoReload, 16'd3);
    io_wr(IoCtrl, 16'h0007);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("nt_int", {14'd0, bus_if.int_b}, 16'h0003);
    end
    io_rd("nt_cnt", IoCount, 16'h0000);
    io_rd("nt_ctrl", IoCtrl, 16'h0000);
    io_rd("nt_rel", IoReload, 16'h0000);
    io_rd("nt_st", IoStatus, 16'h0000);
`endif
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
